// File: rtl/jmisc_pkg.sv
// Shared types and constants for the JERRY misc interrupt sequencer.
package jmisc_pkg;

  localparam int NSRC  = 6;
  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    OFFER,
    CLEAR,
    HOLD
  } seq_state_t;

  localparam logic [IDX_W-1:0] SRC_EXT  = 3'd0;
  localparam logic [IDX_W-1:0] SRC_DSP  = 3'd1;
  localparam logic [IDX_W-1:0] SRC_TIM0 = 3'd2;
  localparam logic [IDX_W-1:0] SRC_TIM1 = 3'd3;
  localparam logic [IDX_W-1:0] SRC_UART = 3'd4;
  localparam logic [IDX_W-1:0] SRC_I2S  = 3'd5;

  // Ack field of an INT1 write: one bit per source, in din[13:8].
  function automatic logic [5:0] onehot6(input logic [IDX_W-1:0] idx);
    logic [5:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/jmisc_prio_pick.sv
// Rotating priority encoder: first set request scanning upward from ptr, with wrap.
module jmisc_prio_pick
  import jmisc_pkg::*;
#(
  parameter int N = NSRC
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int pos;
    // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/jmisc_irq_seq.sv
// Interrupt sequencer: picks a pending source, offers it to the CPU, then
// issues the INT1 clear write itself on a free jmisc clk_en slot.
module jmisc_irq_seq
  import jmisc_pkg::*;
#(
  parameter int ROTATE  = 1,
  parameter int HOLDOFF = 2
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             clk_en,
  input  logic [NSRC-1:0]  pend,
  input  logic             host_int1w,
  input  logic [15:0]      host_din,
  input  logic             irq_ack,
  output logic             irq_req,
  output logic [IDX_W-1:0] irq_vec,
  output logic             busy,
  output logic             int1w,
  output logic [15:0]      din
);

  localparam int HCNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HCNT_W-1:0] HOLD_LAST = (HOLDOFF > 1) ? HCNT_W'(HOLDOFF - 1) : '0;

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  winner_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [5:0]        ie_shadow_q;
  logic [HCNT_W-1:0] hold_cnt_q;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  pick_ptr;
  logic              seq_w;
  logic [15:0]       seq_din;

  assign pick_ptr = (ROTATE != 0) ? rr_ptr_q : '0;

  jmisc_prio_pick #(.N(NSRC)) u_pick (
    .req   (pend),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    seq_w   = 1'b0;
    irq_req = 1'b0;
    case (state_q)
      IDLE:   if (|pend) state_d = SELECT;
      SELECT: state_d = pick_valid ? OFFER : IDLE;
      OFFER: begin
        irq_req = 1'b1;
        // Ack beats a simultaneous host-side clear of the same bit.
        if (irq_ack)              state_d = CLEAR;
        else if (!pend[winner_q]) state_d = HOLD;
      end
      CLEAR: begin
        if (clk_en && !host_int1w) begin
          seq_w   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD:    if (hold_cnt_q == HOLD_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous (sampled on sys_clk), and all state uses non-blocking assignments.
  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state_q     <= IDLE;
      winner_q    <= '0;
      rr_ptr_q    <= '0;
      ie_shadow_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (host_int1w) ie_shadow_q <= host_din[5:0];
      if (state_q == SELECT && pick_valid) winner_q <= pick_idx;
      if (seq_w && ROTATE != 0)
        rr_ptr_q <= (winner_q == IDX_W'(NSRC - 1)) ? '0 : winner_q + 1'b1;
      hold_cnt_q <= (state_q == HOLD) ? hold_cnt_q + 1'b1 : '0;
    end
  end

  // The clear write re-states the current enables so ie[5:0] is never disturbed.
  assign seq_din = {2'b00, onehot6(winner_q), 2'b00, ie_shadow_q};

  assign int1w   = host_int1w | (seq_w & resetl);
  assign din     = host_int1w ? host_din : seq_din;
  assign irq_vec = winner_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_jmisc_irq_seq.sv
// Directed bench for jmisc_irq_seq: a rotating instance plus a fixed-priority instance on shared inputs.
module tb_jmisc_irq_seq;

  logic        sys_clk;
  logic        resetl;
  logic        clk_en;
  logic [5:0]  pend;
  logic        host_int1w;
  logic [15:0] host_din;
  logic        irq_ack;

  logic        irq_req, busy, int1w;
  logic [2:0]  irq_vec;
  logic [15:0] din;
  logic        f_irq_req, f_busy, f_int1w;
  logic [2:0]  f_irq_vec;
  logic [15:0] f_din;

  int n_checks = 0;
  int n_fail   = 0;

  jmisc_irq_seq #(.ROTATE(1), .HOLDOFF(2)) dut (
    .sys_clk(sys_clk), .resetl(resetl), .clk_en(clk_en), .pend(pend),
    .host_int1w(host_int1w), .host_din(host_din), .irq_ack(irq_ack),
    .irq_req(irq_req), .irq_vec(irq_vec), .busy(busy), .int1w(int1w), .din(din)
  );

  jmisc_irq_seq #(.ROTATE(0), .HOLDOFF(2)) dut_fixed (
    .sys_clk(sys_clk), .resetl(resetl), .clk_en(clk_en), .pend(pend),
    .host_int1w(host_int1w), .host_din(host_din), .irq_ack(irq_ack),
    .irq_req(f_irq_req), .irq_vec(f_irq_vec), .busy(f_busy), .int1w(f_int1w), .din(f_din)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic to_neg();
    @(negedge sys_clk);
  endtask

  task automatic to_next();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic quiet_inputs();
    clk_en = 1'b0; pend = '0; host_int1w = 1'b0; host_din = '0; irq_ack = 1'b0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    resetl = 1'b0;
    to_next();
    to_next();
    resetl = 1'b1;
  endtask

  task automatic test_reset();
    quiet_inputs();
    resetl = 1'b0;
    to_next();
    host_int1w = 1'b1; host_din = 16'hABCD; pend = 6'h3F;
    to_neg();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", irq_req); end
    n_checks++; if (irq_vec !== 3'd0) begin n_fail++; $display("FAIL rst_vec: got %0d want 0", irq_vec); end
    n_checks++; if (int1w !== 1'b1) begin n_fail++; $display("FAIL rst_int1w_follow: got %b want 1", int1w); end
    n_checks++; if (din !== 16'hABCD) begin n_fail++; $display("FAIL rst_din: got %h want abcd", din); end
    to_next();
    to_neg();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_pend: got %b want 0", busy); end
    to_next();
    resetl = 1'b1;
    quiet_inputs();
  endtask

  task automatic test_basic();
    do_reset();
    host_int1w = 1'b1; host_din = 16'h003F;
    to_neg();
    n_checks++; if (int1w !== 1'b1 || din !== 16'h003F) begin n_fail++; $display("FAIL t1_hostw: got %b/%h want 1/003f", int1w, din); end
    to_next();
    host_int1w = 1'b0; host_din = '0; pend = 6'b000100;
    to_neg();
    n_checks++; if (irq_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL t1_idle: got req=%b busy=%b want 0/0", irq_req, busy); end
    to_next();
    to_neg();
    n_checks++; if (irq_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL t1_select: got req=%b busy=%b want 0/1", irq_req, busy); end
    to_next();
    irq_ack = 1'b1;
    to_neg();
    n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL t1_latency: got %b want 1", irq_req); end
    n_checks++; if (irq_vec !== 3'd2) begin n_fail++; $display("FAIL t1_vec: got %0d want 2", irq_vec); end
    to_next();
    irq_ack = 1'b0;
    to_neg();
    n_checks++; if (irq_req !== 1'b0 || int1w !== 1'b0) begin n_fail++; $display("FAIL t1_clear_wait: got req=%b w=%b want 0/0", irq_req, int1w); end
    to_next();
    clk_en = 1'b1;
    to_neg();
    n_checks++; if (int1w !== 1'b1 || din !== 16'h043F) begin n_fail++; $display("FAIL t1_clear: got %b/%h want 1/043f", int1w, din); end
    to_next();
    clk_en = 1'b0; pend = '0;
    to_neg();
    n_checks++; if (int1w !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL t1_hold0: got w=%b busy=%b want 0/1", int1w, busy); end
    to_next();
    to_neg();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_hold1: got %b want 1", busy); end
    to_next();
    to_neg();
    n_checks++; if (busy !== 1'b0 || irq_vec !== 3'd2) begin n_fail++; $display("FAIL t1_idle_end: got busy=%b vec=%0d want 0/2", busy, irq_vec); end
    to_next();
  endtask

  task automatic test_rotate();
    do_reset();
    pend = 6'b001010;
    to_next();
    to_next();
    irq_ack = 1'b1;
    to_neg();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd1) begin n_fail++; $display("FAIL t2_rr_first: got req=%b vec=%0d want 1/1", irq_req, irq_vec); end
    n_checks++; if (f_irq_vec !== 3'd1) begin n_fail++; $display("FAIL t2_fix_first: got %0d want 1", f_irq_vec); end
    to_next();
    irq_ack = 1'b0; clk_en = 1'b1;
    to_neg();
    n_checks++; if (int1w !== 1'b1 || din !== 16'h0200) begin n_fail++; $display("FAIL t2_clear1: got %b/%h want 1/0200", int1w, din); end
    to_next();
    clk_en = 1'b0;
    to_next();
    to_next();
    to_next();
    to_next();
    to_neg();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd3) begin n_fail++; $display("FAIL t2_rr_second: got req=%b vec=%0d want 1/3", irq_req, irq_vec); end
    n_checks++; if (f_irq_req !== 1'b1 || f_irq_vec !== 3'd1) begin n_fail++; $display("FAIL t2_fix_second: got req=%b vec=%0d want 1/1", f_irq_req, f_irq_vec); end
    irq_ack = 1'b1;
    to_next();
    irq_ack = 1'b0; pend = '0; clk_en = 1'b1;
    to_neg();
    n_checks++; if (din !== 16'h0800) begin n_fail++; $display("FAIL t2_rr_clear2: got %h want 0800", din); end
    n_checks++; if (f_din !== 16'h0200) begin n_fail++; $display("FAIL t2_fix_clear2: got %h want 0200", f_din); end
    to_next();
    clk_en = 1'b0;
  endtask

  task automatic test_host_collision();
    do_reset();
    host_int1w = 1'b1; host_din = 16'h003F;
    to_next();
    host_int1w = 1'b0; host_din = '0; pend = 6'b000001;
    to_next();
    to_next();
    irq_ack = 1'b1;
    to_neg();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd0) begin n_fail++; $display("FAIL t3_offer: got req=%b vec=%0d want 1/0", irq_req, irq_vec); end
    to_next();
    irq_ack = 1'b0; clk_en = 1'b1; host_int1w = 1'b1; host_din = 16'h0005;
    to_neg();
    n_checks++; if (int1w !== 1'b1 || din !== 16'h0005) begin n_fail++; $display("FAIL t3_host_wins: got %b/%h want 1/0005", int1w, din); end
    to_next();
    host_int1w = 1'b0; host_din = '0; clk_en = 1'b0;
    to_neg();
    n_checks++; if (int1w !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL t3_retry_wait: got w=%b busy=%b want 0/1", int1w, busy); end
    to_next();
    clk_en = 1'b1;
    to_neg();
    n_checks++; if (int1w !== 1'b1 || din !== 16'h0105) begin n_fail++; $display("FAIL t3_retry: got %b/%h want 1/0105", int1w, din); end
    to_next();
    clk_en = 1'b0; pend = '0;
  endtask

  task automatic test_host_ack();
    do_reset();
    pend = 6'b010000;
    to_next();
    to_next();
    to_neg();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd4) begin n_fail++; $display("FAIL t4_offer: got req=%b vec=%0d want 1/4", irq_req, irq_vec); end
    to_next();
    host_int1w = 1'b1; host_din = 16'h1000; pend = '0;
    to_neg();
    n_checks++; if (int1w !== 1'b1 || din !== 16'h1000 || irq_req !== 1'b1) begin n_fail++; $display("FAIL t4_hostack: got w=%b din=%h req=%b want 1/1000/1", int1w, din, irq_req); end
    to_next();
    host_int1w = 1'b0; host_din = '0; clk_en = 1'b1;
    to_neg();
    n_checks++; if (irq_req !== 1'b0 || int1w !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL t4_drop: got req=%b w=%b busy=%b want 0/0/1", irq_req, int1w, busy); end
    n_checks++; if (irq_vec !== 3'd4) begin n_fail++; $display("FAIL t4_vec_hold: got %0d want 4", irq_vec); end
    to_next();
    to_neg();
    n_checks++; if (int1w !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL t4_hold1: got w=%b busy=%b want 0/1", int1w, busy); end
    to_next();
    to_neg();
    n_checks++; if (int1w !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL t4_idle: got w=%b busy=%b want 0/0", int1w, busy); end
    to_next();
    clk_en = 1'b0;
  endtask

  task automatic test_reset_in_clear();
    do_reset();
    host_int1w = 1'b1; host_din = 16'h003F;
    to_next();
    host_int1w = 1'b0; host_din = '0; pend = 6'b000001;
    to_next();
    to_next();
    irq_ack = 1'b1;
    to_next();
    irq_ack = 1'b0; resetl = 1'b0;
    to_neg();
    n_checks++; if (int1w !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL t5_in_clear: got w=%b busy=%b want 0/1", int1w, busy); end
    to_next();
    resetl = 1'b1; pend = '0; clk_en = 1'b1;
    to_neg();
    n_checks++; if (busy !== 1'b0 || irq_req !== 1'b0 || int1w !== 1'b0) begin n_fail++; $display("FAIL t5_after_rst: got busy=%b req=%b w=%b want 0/0/0", busy, irq_req, int1w); end
    to_next();
    clk_en = 1'b0; pend = 6'b000001;
    to_next();
    to_next();
    irq_ack = 1'b1;
    to_next();
    irq_ack = 1'b0; clk_en = 1'b1;
    to_neg();
    n_checks++; if (int1w !== 1'b1 || din !== 16'h0100) begin n_fail++; $display("FAIL t5_ie_cleared: got %b/%h want 1/0100", int1w, din); end
    to_next();
    clk_en = 1'b0; pend = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    pend = 6'b000100;
    to_next();
    to_next();
    irq_ack = 1'b1; pend = '0;
    to_neg();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd2) begin n_fail++; $display("FAIL t6_offer: got req=%b vec=%0d want 1/2", irq_req, irq_vec); end
    to_next();
    irq_ack = 1'b0; clk_en = 1'b1;
    to_neg();
    n_checks++; if (int1w !== 1'b1 || din !== 16'h0400) begin n_fail++; $display("FAIL t6_clear: got %b/%h want 1/0400", int1w, din); end
    to_next();
    clk_en = 1'b0;
    to_neg();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t6_hold: got %b want 1", busy); end
    to_next();
    to_next();
    to_neg();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t6_idle: got %b want 0", busy); end
    to_next();
    to_neg();
    n_checks++; if (busy !== 1'b0 || irq_req !== 1'b0) begin n_fail++; $display("FAIL t6_stay_idle: got busy=%b req=%b want 0/0", busy, irq_req); end
    to_next();
  endtask

  initial begin
    quiet_inputs();
    resetl = 1'b0;
    test_reset();
    test_basic();
    test_rotate();
    test_host_collision();
    test_host_ack();
    test_reset_in_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
